// File: rtl/fas_pkg.sv
// rtl/fas_pkg.sv - shared FAS frame types and constants
package fas_pkg;

  localparam int FAS_NPT = 16;
  localparam int FAS_DW  = 32;

  // One complex point: real part in the upper half, imaginary in the lower
  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
  } fas_word_t;

  // Element 0 is point 0 (the first word in the output stream)
  typedef fas_word_t [FAS_NPT-1:0] fas_frame_t;

endpackage

// File: rtl/fas_frame_buf.sv
// rtl/fas_frame_buf.sv - two-slot frame register bank with word read port
module fas_frame_buf
  import fas_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en_i,
  input  logic                      wr_sel_i,
  input  logic [FAS_NPT*FAS_DW-1:0] wr_frame_i,
  input  logic                      rd_sel_i,
  input  logic [3:0]                rd_idx_i,
  output logic [FAS_DW-1:0]         rd_word_o
);

  fas_frame_t slot0_q;
  fas_frame_t slot1_q;

  // Whole-frame capture into the selected slot; storage clears on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
    end else if (wr_en_i) begin
      if (wr_sel_i) begin
        slot1_q <= wr_frame_i;
      end else begin
        slot0_q <= wr_frame_i;
      end
    end
  end

  // Read word is a plain mux over registered storage, so it holds while stalled
  always_comb begin
    rd_word_o = rd_sel_i ? slot1_q[rd_idx_i] : slot0_q[rd_idx_i];
  end

endmodule

// File: rtl/fas_fft_serializer.sv
// rtl/fas_fft_serializer.sv - buffers parallel FFT frames and streams them word by word
module fas_fft_serializer
  import fas_pkg::*;
#(
  parameter int DW  = 32,
  parameter int NPT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fft_valid,
  input  logic [DW-1:0] fft_d0,
  input  logic [DW-1:0] fft_d1,
  input  logic [DW-1:0] fft_d2,
  input  logic [DW-1:0] fft_d3,
  input  logic [DW-1:0] fft_d4,
  input  logic [DW-1:0] fft_d5,
  input  logic [DW-1:0] fft_d6,
  input  logic [DW-1:0] fft_d7,
  input  logic [DW-1:0] fft_d8,
  input  logic [DW-1:0] fft_d9,
  input  logic [DW-1:0] fft_d10,
  input  logic [DW-1:0] fft_d11,
  input  logic [DW-1:0] fft_d12,
  input  logic [DW-1:0] fft_d13,
  input  logic [DW-1:0] fft_d14,
  input  logic [DW-1:0] fft_d15,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [3:0]    out_idx,
  output logic          out_last,
  output logic          overflow,
  output logic [7:0]    drop_cnt,
  output logic [7:0]    frame_cnt
);

  localparam logic [3:0] LAST_IDX = 4'(NPT - 1);

  logic [1:0] occ_q, occ_d;
  logic       wr_sel_q, wr_sel_d;
  logic       rd_sel_q, rd_sel_d;
  logic [3:0] idx_q, idx_d;
  logic       ovf_q, ovf_d;
  logic [7:0] drop_q, drop_d;
  logic [7:0] fcnt_q, fcnt_d;

  logic       hs;
  logic       pop;
  logic       accept;
  logic [NPT*DW-1:0] in_frame;

  // fft_d0 lands in element 0 so it is emitted first
  assign in_frame = {fft_d15, fft_d14, fft_d13, fft_d12, fft_d11, fft_d10, fft_d9, fft_d8,
                     fft_d7,  fft_d6,  fft_d5,  fft_d4,  fft_d3,  fft_d2,  fft_d1, fft_d0};

  assign out_valid = (occ_q != 2'd0);
  assign out_last  = out_valid & (idx_q == LAST_IDX);
  assign hs        = out_valid & out_ready;
  assign pop       = hs & out_last;
  // A full buffer still accepts when the head frame finishes on this same edge
  assign accept    = fft_valid & ((occ_q != 2'd2) | pop);

  assign out_idx   = idx_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;
  assign frame_cnt = fcnt_q;

  fas_frame_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (accept),
    .wr_sel_i   (wr_sel_q),
    .wr_frame_i (in_frame),
    .rd_sel_i   (rd_sel_q),
    .rd_idx_i   (idx_q),
    .rd_word_o  (out_data)
  );

  // Next-state for occupancy, pointers, read index and drop/frame counters
  always_comb begin
    occ_d    = occ_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    fcnt_d   = fcnt_q;

    if (accept) begin
      wr_sel_d = ~wr_sel_q;
    end else if (fft_valid) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end

    if (accept && !pop) begin
      occ_d = occ_q + 2'd1;
    end else if (pop && !accept) begin
      occ_d = occ_q - 2'd1;
    end

    if (pop) begin
      idx_d    = 4'd0;
      rd_sel_d = ~rd_sel_q;
      fcnt_d   = fcnt_q + 8'd1;
    end else if (hs) begin
      idx_d = idx_q + 4'd1;
    end
  end

  // Control state registers; reset discards any partially emitted frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q    <= 2'd0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      idx_q    <= 4'd0;
      ovf_q    <= 1'b0;
      drop_q   <= 8'd0;
      fcnt_q   <= 8'd0;
    end else begin
      occ_q    <= occ_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      fcnt_q   <= fcnt_d;
    end
  end

endmodule

// File: doc/fas_fft_serializer.md
# fas_fft_serializer

Output-side companion to the FAS core. Captures each 16-point FFT frame that FAS presents in parallel on `fft_valid` / `fft_d0..fft_d15`. Buffers up to two frames and replays them as a 32-bit word stream under valid/ready flow control, for a downstream memory writer or host port. Frames that arrive with no free slot are dropped and counted, never partially overwritten.

## Interface
Parameters:
- `DW`, 32: word width, `{real[15:0], imag[15:0]}`; same packing as `fft_dN`.
- `NPT`, 16: points per frame; fixed at 16 in this revision.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `fft_valid`  in  1: one-cycle frame strobe from FAS.
- `fft_d0` .. `fft_d15`  in  32 each: frame points, valid with `fft_valid`.
- `out_valid`  out  1: stream word available.
- `out_ready`  in  1: downstream accepts the word.
- `out_data`  out  32: current word.
- `out_idx`  out  4: point index of `out_data` (0..15).
- `out_last`  out  1: high when `out_idx == 15` and `out_valid`.
- `overflow`  out  1: sticky; a frame was dropped since reset.
- `drop_cnt`  out  8: dropped-frame count, saturates at 255.
- `frame_cnt`  out  8: frames fully emitted, wraps at 256.

## Operation
- Two frame slots, each 16 x 32 bits.
- State: `wr_sel` (slot for the next capture), `rd_sel` (slot being emitted), `occ` (0..2), `idx` (4-bit read index).
- Handshake: `hs = out_valid & out_ready`. A word transfers only on `hs`.
- `pop = hs & out_last`.
- Capture:
  - On `fft_valid`, if `occ < 2` or (`occ == 2` and `pop`), all 16 inputs latch into slot `wr_sel` and `wr_sel` toggles.
  - Otherwise the frame is dropped: `overflow` sets, `drop_cnt` increments (saturating), and no storage or pointer changes.
- `occ` update:
  - +1 on accept without `pop`.
  - -1 on `pop` without accept.
  - Unchanged when both or neither occur.
- `out_valid = (occ != 0)`.
- `out_data = slot[rd_sel][idx]`. Muxed from registers, so it is held stable while `out_valid & !out_ready`.
- Read index:
  - `hs` and `idx != 15`: `idx` increments.
  - `pop`: `idx` returns to 0, `rd_sel` toggles, `frame_cnt` increments.
- Point order in the stream is `fft_d0` first, `fft_d15` last.
- `fft_valid` while `occ == 0`: the frame is visible on the next cycle.
- Reset mid-frame: all state clears immediately. A partially emitted frame is discarded and not resumed.

## Timing
- Reset values:
  - `out_valid`, `out_last`, `overflow` = 0.
  - `out_idx`, `drop_cnt`, `frame_cnt`, `occ`, `wr_sel`, `rd_sel` = 0.
  - `out_data` = 0 (slot storage cleared).
- Latency: `fft_valid` sampled at edge N gives `out_valid` = 1 and `out_idx` = 0 after edge N.
- With `out_ready` held high, words 0..15 go out on edges N+1..N+16 and `occ` decrements at edge N+16.
- Throughput: one word per cycle. A frame needs 16 cycles, which matches the FAS frame rate of one frame per 16 input samples, so with `out_ready` held high no frame is dropped.
- `fft_valid` may be high on consecutive cycles; each strobe is treated as a separate frame.
- All outputs are registered or derived only from registered state; there are no combinational paths from `fft_*` to the outputs.
- `out_ready` drives `out_data`, `out_idx` and `out_last` only through registered state, so it reaches them one edge later. Consumers may leave `out_ready` low indefinitely.

## Structure
- Shared package `fas_pkg`:
  - `FAS_NPT = 16`, `FAS_DW = 32`.
  - `fas_word_t` (32-bit packed struct: `re`, `im`, 16 bits each).
  - `fas_frame_t` (array of 16 `fas_word_t`).
- Sub-module `fas_frame_buf`:
  - Two-slot frame register bank.
  - Write port: whole frame, plus slot select.
  - Read port: slot select plus index, giving one word.
- Top-level contents: control (`occ`, pointers, `idx`), drop logic and counters.

## Test plan
- Single frame, `fft_dN = {16'hN, 16'hF0+N}`, `out_ready` = 1:
  - 16 words on consecutive cycles, `out_idx` 0..15.
  - `out_last` on word 15 only.
  - `frame_cnt` = 1.
  - `out_valid` low afterwards.
- Backpressure: toggle `out_ready` every cycle during one frame:
  - `out_data` holds while ready is low.
  - All 16 words arrive in order.
  - Frame takes 31-32 cycles.
- Back-to-back frames A, B on consecutive `fft_valid` cycles, `out_ready` = 1:
  - 32 contiguous words, A then B, no bubble.
  - `overflow` = 0.
- Third frame C while `occ == 2` and `out_ready` = 0:
  - C dropped; `overflow` = 1, `drop_cnt` = 1.
  - Only A and B emitted later.
- Simultaneous: `fft_valid` on the same edge as the `out_last` handshake with `occ == 2`:
  - Frame accepted, `occ` stays 2, no drop.
- Reset asserted after 7 words of a frame:
  - All outputs return to reset values within the same cycle.
  - A following frame streams from `out_idx` 0.
